// File: rtl/comb_check_pkg.sv
// Shared types and default widths for the combinational response checker.
// No logic here; latency and backpressure are properties of the checker itself.
package comb_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N_IN  = 3;
    localparam int DEF_N_OUT = 3;

endpackage

// File: rtl/cov_tracker.sv
// Coverage map of 2**N_IN vectors: o_hit and o_all_next are combinational on the current map.
// Map updates one cycle after i_set; i_clr has priority and the block never stalls.
module cov_tracker #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_set,
    input  logic [N_IN-1:0] i_idx,
    output logic            o_hit,
    output logic            o_all_next
);
    localparam int NV = 2**N_IN;

    logic [NV-1:0] r_map;
    logic [NV-1:0] w_onehot;

    assign w_onehot   = {{(NV-1){1'b0}}, 1'b1} << i_idx;
    assign o_hit      = r_map[i_idx];
    // True when setting i_idx now would complete the sweep.
    assign o_all_next = &(r_map | w_onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map <= '0;
        end else if (i_clr) begin
            r_map <= '0;
        end else if (i_set) begin
            r_map <= r_map | w_onehot;
        end
    end

endmodule

// File: rtl/comb_response_checker.sv
// Checks stimulus/response pairs against EXP_TABLE and reports once every vector is seen.
// Results register one cycle after accept; in_ready high only while a sweep is in progress.
module comb_response_checker
    import comb_check_pkg::*;
#(
    parameter int                         N_IN      = DEF_N_IN,
    parameter int                         N_OUT     = DEF_N_OUT,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TABLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic [N_OUT-1:0] in_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN:0]    dup_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic [N_OUT-1:0] first_fail_resp
);
    localparam logic [N_IN:0] CNT_MAX = (N_IN+1)'(2**N_IN);

    state_t             r_state;
    state_t             w_state_next;
    logic [N_IN:0]      r_err;
    logic [N_IN:0]      r_dup;
    logic [N_IN-1:0]    r_ffv;
    logic [N_OUT-1:0]   r_ffr;
    logic               r_pass;

    logic               w_ready;
    logic               w_accept;
    logic [N_OUT-1:0]   w_exp;
    logic               w_mis;
    logic               w_hit;
    logic               w_all_next;
    logic               w_complete;
    logic [N_IN:0]      w_err_next;
    logic [N_IN:0]      w_dup_next;

    assign w_ready    = (r_state == CHECK);
    // A start in the same cycle discards the pair even though in_ready may be high.
    assign w_accept   = in_valid & w_ready & ~start;
    assign w_exp      = EXP_TABLE[int'(in_vec)*N_OUT +: N_OUT];
    assign w_mis      = w_accept && (in_resp != w_exp);
    assign w_complete = w_accept && w_all_next;

    assign w_err_next = (w_mis && (r_err != CNT_MAX)) ? r_err + 1'b1 : r_err;
    assign w_dup_next = (w_accept && w_hit && (r_dup != CNT_MAX)) ? r_dup + 1'b1 : r_dup;

    cov_tracker #(
        .N_IN (N_IN)
    ) u_cov (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (start),
        .i_set      (w_accept),
        .i_idx      (in_vec),
        .o_hit      (w_hit),
        .o_all_next (w_all_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CHECK;
            CHECK: begin
                if (start)           w_state_next = CHECK;
                else if (w_complete) w_state_next = DONE;
            end
            DONE:    if (start) w_state_next = CHECK;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= '0;
            r_dup  <= '0;
            r_ffv  <= '0;
            r_ffr  <= '0;
            r_pass <= 1'b0;
        end else if (start) begin
            r_err  <= '0;
            r_dup  <= '0;
            r_ffv  <= '0;
            r_ffr  <= '0;
            r_pass <= 1'b0;
        end else begin
            r_err <= w_err_next;
            r_dup <= w_dup_next;
            if (w_mis && (r_err == '0)) begin
                r_ffv <= in_vec;
                r_ffr <= in_resp;
            end
            // Verdict includes the completing pair itself.
            if (w_complete) begin
                r_pass <= (w_err_next == '0) && (w_dup_next == '0);
            end
        end
    end

    assign in_ready        = w_ready;
    assign busy            = (r_state == CHECK);
    assign done            = (r_state == DONE);
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign dup_count       = r_dup;
    assign first_fail_vec  = r_ffv;
    assign first_fail_resp = r_ffr;

endmodule
